// File: rtl/pixel_writer.sv
// Pixel stream sink: clips rasterizer pixels to the screen, converts them to
// framebuffer byte addresses, buffers them in a small FIFO and issues one
// req/ack memory write per visible pixel, strictly in acceptance order.
// Clipped pixels travel through the FIFO too, so pix_last/done ordering holds.
module pixel_writer #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned BPP_BYTES  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fb_base,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  input  logic [31:0] pix_color,
  input  logic        pix_last,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] pix_count,
  output logic [15:0] clip_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] color;
    logic        last;
    logic        drop;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  entry_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  entry_t        in_entry, head;
  state_t        state, next_state;
  logic          push, pop, load, inc_pix, done_next;

  // Ready is derived from the registered count only, so a same-cycle pop
  // does not open a slot until the following cycle.
  assign pix_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign push      = pix_valid & pix_ready;
  assign head      = fifo_mem[rd_ptr];
  assign mem_req   = (state == REQ);
  assign busy      = (fifo_count != '0) | (state == REQ);

  // Build the FIFO entry: clip test and 32-bit wrapping byte address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    in_entry       = '0;
    in_entry.addr  = fb_base + (32'(pix_y) * SCREEN_W + 32'(pix_x)) * BPP_BYTES;
    in_entry.color = pix_color;
    in_entry.last  = pix_last;
    in_entry.drop  = (32'(pix_x) >= SCREEN_W) | (32'(pix_y) >= SCREEN_H);
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; fifo_count alone says which slots hold valid data.
    if (push) fifo_mem[wr_ptr] <= in_entry;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Write FSM next-state and control: drop clipped heads, request visible ones.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    inc_pix    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          if (head.drop) begin
            pop       = 1'b1;
            done_next = head.last;
          end else begin
            load       = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          pop        = 1'b1;
          inc_pix    = 1'b1;
          done_next  = head.last;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Memory write address/data; they hold their last value between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      mem_addr  <= head.addr;
      mem_wdata <= head.color;
    end
  end

  // done pulse and saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      pix_count  <= '0;
      clip_count <= '0;
    end else begin
      done <= done_next;
      if (inc_pix && pix_count != 16'hFFFF)                   pix_count  <= pix_count + 1'b1;
      if (push && in_entry.drop && clip_count != 16'hFFFF)   clip_count <= clip_count + 1'b1;
    end
  end

endmodule
